// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer_pkg
//  Brief    : Shared state encoding, next-PC select codes and defaults for the
//             instruction-fetch sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_VALID = 3'd2,
        ST_HALT  = 3'd3,
        ST_ERROR = 3'd4
    } fetch_state_e;

    localparam logic [1:0] SEL_SEQ  = 2'b00;
    localparam logic [1:0] SEL_BR   = 2'b01;
    localparam logic [1:0] SEL_J    = 2'b10;
    localparam logic [1:0] SEL_HOLD = 2'b11;

    localparam logic [5:0] DEFAULT_HALT_OP = 6'h3F;
    localparam int         TIMER_WIDTH     = 8;

    // Jump outranks a taken branch when both decode in the same instruction.
    function automatic logic [1:0] next_pc_sel(
        input logic jump,
        input logic branch,
        input logic zero
    );
        logic [1:0] sel;
        sel = SEL_SEQ;
        if (jump) begin
            sel = SEL_J;
        end else if (branch && zero) begin
            sel = SEL_BR;
        end
        return sel;
    endfunction

    function automatic logic is_redirect(
        input logic jump,
        input logic branch,
        input logic zero
    );
        return jump || (branch && zero);
    endfunction

endpackage : fetch_sequencer_pkg
`default_nettype wire

// File: rtl/fetch_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_timeout_counter
//  Brief    : 8-bit memory wait timer; expired flags the last permitted
//             waiting cycle so the caller can leave on the following edge.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_timeout_counter
    import fetch_sequencer_pkg::*;
#(
    parameter int LIMIT = 15
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMER_WIDTH-1:0] LAST_WAIT = TIMER_WIDTH'(LIMIT - 1);

    logic [TIMER_WIDTH-1:0] count_q;
    logic [TIMER_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TIMER_WIDTH'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The count holds the waits already elapsed, so the current waiting
    // cycle is the LIMIT-th one when the count equals LIMIT-1.
    assign expired = (count_q == LAST_WAIT);

endmodule : fetch_timeout_counter
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Brief    : Multi-cycle fetch controller: memory request, instruction
//             register load, downstream handshake, PC commit, halt, timeout
//             and performance counters.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int         IMEM_TIMEOUT = 15,
    parameter int         CNT_WIDTH    = 32,
    parameter logic [5:0] HALT_OP      = DEFAULT_HALT_OP
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    output logic                 IMem_Req,
    input  logic                 IMem_Ack,
    input  logic [5:0]           Op,
    output logic                 Inst_Load,
    output logic                 Inst_Valid,
    input  logic                 Inst_Ready,
    input  logic                 Branch,
    input  logic                 Jump,
    input  logic                 Zero,
    output logic                 PC_Write,
    output logic [1:0]           PC_Sel,
    output logic                 Halted,
    output logic                 Timeout_Err,
    output logic [CNT_WIDTH-1:0] Fetch_Count,
    output logic [CNT_WIDTH-1:0] Redirect_Count
);

    fetch_state_e state_q;
    fetch_state_e state_d;

    logic                 halt_pending_q;
    logic                 halt_pending_d;
    logic [CNT_WIDTH-1:0] fetch_cnt_q;
    logic [CNT_WIDTH-1:0] fetch_cnt_d;
    logic [CNT_WIDTH-1:0] redir_cnt_q;
    logic [CNT_WIDTH-1:0] redir_cnt_d;

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    fetch_timeout_counter #(
        .LIMIT   (IMEM_TIMEOUT)
    ) u_timeout (
        .Clock   (Clock),
        .Reset   (Reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_comb begin
        state_d        = state_q;
        halt_pending_d = halt_pending_q;
        fetch_cnt_d    = fetch_cnt_q;
        redir_cnt_d    = redir_cnt_q;
        timer_clear    = 1'b1;
        timer_enable   = 1'b0;
        IMem_Req       = 1'b0;
        Inst_Load      = 1'b0;
        Inst_Valid     = 1'b0;
        PC_Write       = 1'b0;
        PC_Sel         = SEL_HOLD;
        Halted         = 1'b0;
        Timeout_Err    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                IMem_Req    = 1'b1;
                timer_clear = 1'b0;
                if (IMem_Ack) begin
                    Inst_Load      = 1'b1;
                    halt_pending_d = (Op == HALT_OP);
                    timer_clear    = 1'b1;
                    state_d        = ST_VALID;
                end else begin
                    timer_enable = 1'b1;
                    if (timer_expired) begin
                        state_d = ST_ERROR;
                    end
                end
            end

            ST_VALID: begin
                Inst_Valid = 1'b1;
                if (Inst_Ready) begin
                    PC_Write    = 1'b1;
                    PC_Sel      = next_pc_sel(Jump, Branch, Zero);
                    fetch_cnt_d = fetch_cnt_q + CNT_WIDTH'(1);
                    if (is_redirect(Jump, Branch, Zero)) begin
                        redir_cnt_d = redir_cnt_q + CNT_WIDTH'(1);
                    end
                    // The halt instruction itself still retires and moves the PC.
                    state_d = halt_pending_q ? ST_HALT : ST_REQ;
                end
            end

            ST_HALT: begin
                Halted = 1'b1;
            end

            ST_ERROR: begin
                Timeout_Err = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q        <= ST_IDLE;
            halt_pending_q <= 1'b0;
            fetch_cnt_q    <= '0;
            redir_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            halt_pending_q <= halt_pending_d;
            fetch_cnt_q    <= fetch_cnt_d;
            redir_cnt_q    <= redir_cnt_d;
        end
    end

    assign Fetch_Count    = fetch_cnt_q;
    assign Redirect_Count = redir_cnt_q;

endmodule : fetch_sequencer
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_sequencer
//  Brief    : Self-checking bench for fetch_sequencer with a PC_Sel scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int CW = 4;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          Start = 1'b0;
    logic          IMem_Ack = 1'b0;
    logic [5:0]    Op = 6'h00;
    logic          Inst_Ready = 1'b0;
    logic          Branch = 1'b0;
    logic          Jump = 1'b0;
    logic          Zero = 1'b0;
    logic          IMem_Req;
    logic          Inst_Load;
    logic          Inst_Valid;
    logic          PC_Write;
    logic [1:0]    PC_Sel;
    logic          Halted;
    logic          Timeout_Err;
    logic [CW-1:0] Fetch_Count;
    logic [CW-1:0] Redirect_Count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0]    sel_q[$];
    logic [CW-1:0] exp_fetch = '0;
    logic [CW-1:0] exp_redir = '0;

    fetch_sequencer #(
        .IMEM_TIMEOUT   (15),
        .CNT_WIDTH      (CW),
        .HALT_OP        (6'h3F)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Start          (Start),
        .IMem_Req       (IMem_Req),
        .IMem_Ack       (IMem_Ack),
        .Op             (Op),
        .Inst_Load      (Inst_Load),
        .Inst_Valid     (Inst_Valid),
        .Inst_Ready     (Inst_Ready),
        .Branch         (Branch),
        .Jump           (Jump),
        .Zero           (Zero),
        .PC_Write       (PC_Write),
        .PC_Sel         (PC_Sel),
        .Halted         (Halted),
        .Timeout_Err    (Timeout_Err),
        .Fetch_Count    (Fetch_Count),
        .Redirect_Count (Redirect_Count)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        Reset = 1'b0; Start = 1'b0; IMem_Ack = 1'b0; Op = 6'h00;
        Inst_Ready = 1'b0; Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock); #1;
        sel_q.delete();
        exp_fetch = '0;
        exp_redir = '0;
    endtask

    task automatic start_fetch();
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
    endtask

    // Entered one step after a clock edge with the DUT in REQ; returns one
    // step after the edge that accepts the instruction.
    task automatic fetch_one(input int waits, input int stall, input logic [5:0] op,
                             input logic br, input logic jmp, input logic z,
                             output int valid_cycles, output int load_cycles);
        logic [1:0] exp_sel;
        valid_cycles = 0;
        load_cycles  = 0;
        for (int i = 0; i < waits; i++) begin
            IMem_Ack = 1'b0; #1;
            n_checks++;
            if ({IMem_Req, Inst_Valid, Inst_Load} !== 3'b100)
                $display("FAIL req_wait: req/valid/load=%b expected 100", {IMem_Req, Inst_Valid, Inst_Load});
            else n_pass++;
            if (Inst_Load) load_cycles++;
            @(posedge Clock); #1;
        end
        IMem_Ack = 1'b1; Op = op; #1;
        n_checks++;
        if (Inst_Load !== 1'b1) $display("FAIL inst_load: got %b expected 1", Inst_Load);
        else n_pass++;
        if (Inst_Load) load_cycles++;
        @(posedge Clock); #1;
        IMem_Ack = 1'b0; Op = 6'h00;
        Branch = br; Jump = jmp; Zero = z;
        exp_sel = jmp ? 2'b10 : ((br && z) ? 2'b01 : 2'b00);
        sel_q.push_back(exp_sel);
        exp_fetch = exp_fetch + 1'b1;
        if (jmp || (br && z)) exp_redir = exp_redir + 1'b1;
        for (int i = 0; i < stall; i++) begin
            Inst_Ready = 1'b0; #1;
            if (Inst_Valid) valid_cycles++;
            if (Inst_Load) load_cycles++;
            n_checks++;
            if ({PC_Write, PC_Sel, IMem_Req} !== 4'b0110)
                $display("FAIL stall: write/sel/req=%b expected 0110", {PC_Write, PC_Sel, IMem_Req});
            else n_pass++;
            @(posedge Clock); #1;
        end
        Inst_Ready = 1'b1; #1;
        if (Inst_Valid) valid_cycles++;
        n_checks++;
        if (PC_Write !== 1'b1) $display("FAIL pc_write: got %b expected 1", PC_Write);
        else n_pass++;
        if (PC_Write === 1'b1 && sel_q.size() > 0) begin
            exp_sel = sel_q.pop_front();
            n_checks++;
            if (PC_Sel !== exp_sel) $display("FAIL pc_sel: got %b expected %b", PC_Sel, exp_sel);
            else n_pass++;
        end
        @(posedge Clock); #1;
        Inst_Ready = 1'b0; Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({IMem_Req, Inst_Load, Inst_Valid, PC_Write, Halted, Timeout_Err} !== 6'b000000)
            $display("FAIL reset_flags: got %b expected 000000",
                     {IMem_Req, Inst_Load, Inst_Valid, PC_Write, Halted, Timeout_Err});
        else n_pass++;
        n_checks++;
        if (PC_Sel !== 2'b11) $display("FAIL reset_pc_sel: got %b expected 11", PC_Sel);
        else n_pass++;
        n_checks++;
        if ({Fetch_Count, Redirect_Count} !== '0)
            $display("FAIL reset_counts: fetch=%0d redir=%0d expected 0/0", Fetch_Count, Redirect_Count);
        else n_pass++;
    endtask

    task automatic test_sequential();
        int v, l;
        start_fetch();
        n_checks++;
        if (IMem_Req !== 1'b1) $display("FAIL start_req: got %b expected 1", IMem_Req);
        else n_pass++;
        for (int k = 0; k < 3; k++) fetch_one(1, 0, 6'h08, 1'b0, 1'b0, 1'b0, v, l);
        n_checks++;
        if (Fetch_Count !== 4'd3) $display("FAIL seq_fetch_count: got %0d expected 3", Fetch_Count);
        else n_pass++;
        n_checks++;
        if (Redirect_Count !== 4'd0) $display("FAIL seq_redir_count: got %0d expected 0", Redirect_Count);
        else n_pass++;
    endtask

    task automatic test_branch_jump();
        int v, l;
        fetch_one(0, 0, 6'h04, 1'b1, 1'b0, 1'b1, v, l);
        fetch_one(0, 0, 6'h04, 1'b1, 1'b0, 1'b0, v, l);
        fetch_one(0, 0, 6'h02, 1'b1, 1'b1, 1'b1, v, l);
        n_checks++;
        if (Redirect_Count !== exp_redir)
            $display("FAIL br_redir_count: got %0d expected %0d", Redirect_Count, exp_redir);
        else n_pass++;
        n_checks++;
        if (Fetch_Count !== exp_fetch)
            $display("FAIL br_fetch_count: got %0d expected %0d", Fetch_Count, exp_fetch);
        else n_pass++;
    endtask

    task automatic test_stall();
        int v, l;
        fetch_one(4, 5, 6'h23, 1'b0, 1'b0, 1'b0, v, l);
        n_checks++;
        if (v !== 6) $display("FAIL stall_valid_cycles: got %0d expected 6", v);
        else n_pass++;
        n_checks++;
        if (l !== 1) $display("FAIL stall_load_cycles: got %0d expected 1", l);
        else n_pass++;
    endtask

    task automatic test_timeout_boundary();
        int v, l;
        fetch_one(14, 0, 6'h00, 1'b0, 1'b0, 1'b0, v, l);
        n_checks++;
        if (Timeout_Err !== 1'b0 || IMem_Req !== 1'b1)
            $display("FAIL late_ack_ok: err=%b req=%b expected 0/1", Timeout_Err, IMem_Req);
        else n_pass++;
    endtask

    task automatic test_halt();
        int v, l;
        int req_seen;
        fetch_one(0, 0, 6'h3F, 1'b0, 1'b0, 1'b0, v, l);
        n_checks++;
        if (Halted !== 1'b1) $display("FAIL halted: got %b expected 1", Halted);
        else n_pass++;
        n_checks++;
        if (Fetch_Count !== exp_fetch)
            $display("FAIL halt_fetch_count: got %0d expected %0d", Fetch_Count, exp_fetch);
        else n_pass++;
        req_seen = 0;
        Start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (IMem_Req !== 1'b0 || Halted !== 1'b1) req_seen++;
            @(posedge Clock); #1;
        end
        Start = 1'b0;
        n_checks++;
        if (req_seen !== 0) $display("FAIL halt_no_req: bad cycles %0d expected 0", req_seen);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int bad;
        apply_reset();
        start_fetch();
        bad = 0;
        IMem_Ack = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (IMem_Req !== 1'b1 || Timeout_Err !== 1'b0) bad++;
            @(posedge Clock); #1;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL timeout_wait: bad cycles %0d expected 0", bad);
        else n_pass++;
        n_checks++;
        if ({Timeout_Err, IMem_Req} !== 2'b10)
            $display("FAIL timeout_err: err/req=%b expected 10", {Timeout_Err, IMem_Req});
        else n_pass++;
        IMem_Ack = 1'b1; Op = 6'h01; Inst_Ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (Inst_Load !== 1'b0 || Inst_Valid !== 1'b0 || PC_Write !== 1'b0 || Timeout_Err !== 1'b1) bad++;
            @(posedge Clock); #1;
        end
        IMem_Ack = 1'b0; Op = 6'h00; Inst_Ready = 1'b0;
        n_checks++;
        if (bad !== 0) $display("FAIL error_ignores_ack: bad cycles %0d expected 0", bad);
        else n_pass++;
        apply_reset();
        n_checks++;
        if ({Timeout_Err, IMem_Req, Halted} !== 3'b000)
            $display("FAIL error_reset: err/req/halt=%b expected 000", {Timeout_Err, IMem_Req, Halted});
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int v, l;
        apply_reset();
        start_fetch();
        fetch_one(0, 0, 6'h02, 1'b0, 1'b1, 1'b0, v, l);
        fetch_one(0, 2, 6'h08, 1'b0, 1'b0, 1'b0, v, l);
        IMem_Ack = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        n_checks++;
        if ({IMem_Req, Inst_Valid} !== 2'b00)
            $display("FAIL async_reset_req: req/valid=%b expected 00", {IMem_Req, Inst_Valid});
        else n_pass++;
        n_checks++;
        if ({Fetch_Count, Redirect_Count} !== '0)
            $display("FAIL async_reset_counts: fetch=%0d redir=%0d expected 0/0", Fetch_Count, Redirect_Count);
        else n_pass++;
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock); #1;
        sel_q.delete();
        exp_fetch = '0;
        exp_redir = '0;
        n_checks++;
        if (IMem_Req !== 1'b0) $display("FAIL async_reset_idle: req=%b expected 0", IMem_Req);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int v, l;
        start_fetch();
        for (int k = 0; k < 15; k++) fetch_one(0, 0, 6'h02, 1'b0, 1'b1, 1'b0, v, l);
        n_checks++;
        if ({Fetch_Count, Redirect_Count} !== 8'hFF)
            $display("FAIL pre_wrap: fetch=%0d redir=%0d expected 15/15", Fetch_Count, Redirect_Count);
        else n_pass++;
        fetch_one(0, 0, 6'h02, 1'b0, 1'b1, 1'b0, v, l);
        n_checks++;
        if ({Fetch_Count, Redirect_Count} !== 8'h00)
            $display("FAIL wrap: fetch=%0d redir=%0d expected 0/0", Fetch_Count, Redirect_Count);
        else n_pass++;
        n_checks++;
        if ({Fetch_Count, Redirect_Count} !== {exp_fetch, exp_redir})
            $display("FAIL wrap_model: fetch=%0d redir=%0d expected %0d/%0d",
                     Fetch_Count, Redirect_Count, exp_fetch, exp_redir);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_jump();
        test_stall();
        test_timeout_boundary();
        test_halt();
        test_timeout();
        test_async_reset();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fetch_sequencer
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle controller that sequences the instruction-fetch datapath: PC register, instruction ROM, PC+4 adder, branch adder and jump mux.
- Requests an instruction from a variable-latency instruction memory and loads the instruction register.
- Presents the instruction downstream with a valid/ready handshake.
- On acceptance, commits the next PC by driving PC write-enable and next-PC select.
- Provides halt detection, a memory-timeout watchdog and fetch/redirect performance counters.

Parameters:
IMEM_TIMEOUT, 15, max consecutive REQ cycles without IMem_Ack before error (1..255)
CNT_WIDTH, 32, width of performance counters
HALT_OP, 6'h3F, opcode that halts fetching after it is delivered

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset
Start  input  1  begin fetching; sampled only in IDLE
IMem_Req  output  1  instruction memory request
IMem_Ack  input  1  memory data valid this cycle; ignored outside REQ
Op  input  6  opcode (Inst[31:26]) of returned instruction, valid with IMem_Ack
Inst_Load  output  1  load instruction register this cycle
Inst_Valid  output  1  instruction register holds an undelivered instruction
Inst_Ready  input  1  downstream accepts instruction
Branch  input  1  decoded branch, valid while Inst_Valid
Jump  input  1  decoded jump, valid while Inst_Valid
Zero  input  1  ALU zero flag for the branch compare, valid while Inst_Valid
PC_Write  output  1  PC register update enable
PC_Sel  output  2  00=PC+4, 01=branch target, 10=jump target, 11=hold
Halted  output  1  halt opcode delivered; fetch stopped
Timeout_Err  output  1  sticky memory-timeout error
Fetch_Count  output  CNT_WIDTH  instructions delivered
Redirect_Count  output  CNT_WIDTH  taken branches plus jumps

Behaviour:
- Reset (async, Reset=0):
  - state=IDLE; all outputs 0 except PC_Sel=11; counters, wait timer and halt_pending cleared.
  - Takes effect immediately, including mid-request; IMem_Req drops without waiting for a clock edge.
- States: IDLE, REQ, VALID, HALT, ERROR.
- IDLE: Start=1 -> REQ next cycle.
- REQ: IMem_Req=1 (Moore).
  - IMem_Ack=1: Inst_Load=1 in the same cycle (Mealy); halt_pending <= (Op==HALT_OP); timer cleared; -> VALID.
    - Minimum latency is 1 cycle, ack in the first REQ cycle.
  - IMem_Ack=0: timer++. If timer reaches IMEM_TIMEOUT -> ERROR.
    - With IMEM_TIMEOUT=15: 15 non-ack cycles -> ERROR entered on the following edge.
- VALID: Inst_Valid=1; Inst_Load=0; holds indefinitely while Inst_Ready=0.
  - Inst_Ready=1 (same cycle, Mealy): PC_Write=1; PC_Sel per priority below; Fetch_Count++.
    - Redirect_Count++ when Jump or (Branch & Zero).
    - Next state: HALT if halt_pending, else REQ.
- PC_Sel priority: Jump -> 10; else Branch&Zero -> 01; else 00.
  - Jump+Branch together selects jump.
  - PC_Sel=11 whenever PC_Write=0.
- HALT: Halted=1; no requests; Start ignored; exit only via reset.
  - The halt instruction is delivered, and the PC advances past it.
- ERROR: Timeout_Err=1; IMem_Req=0; no PC updates; exit only via reset.
- Only one instruction is in flight; no new request is issued until the current instruction is accepted.
- Counters wrap modulo 2^CNT_WIDTH (all-ones + 1 -> 0).
- The Inst_Valid -> PC_Write path is combinational through Inst_Ready; no other combinational input-to-output paths except IMem_Ack -> Inst_Load.

Decomposition:
- Shared package holds:
  - state encoding (3-bit: IDLE=0, REQ=1, VALID=2, HALT=3, ERROR=4)
  - PC_Sel constants (SEL_SEQ, SEL_BR, SEL_J, SEL_HOLD)
  - default HALT_OP
- Sub-module fetch_timeout_counter: 8-bit wait timer with clear/enable inputs and an expired output; instantiated once.
- Counters and FSM stay in the top module.

Test Plan:
- Reset low, Start=1, ack 1 cycle after each req, Inst_Ready=1, Branch=Jump=0, 3 instructions -> 3 PC_Write pulses all with PC_Sel=00; Fetch_Count=3; Redirect_Count=0.
- Delivery with Branch=1 and Zero=1, then a second delivery with Branch=1 and Zero=0 -> PC_Sel=01 then 00; Redirect_Count=1. Jump=1 and Branch=1 with Zero=1 -> PC_Sel=10.
- Ack after 4 wait cycles, Inst_Ready held 0 for 5 cycles -> Inst_Load exactly 1 cycle; Inst_Valid 1 for 6 cycles; no PC_Write until Ready; IMem_Req=0 throughout VALID.
- Op=6'h3F returned and accepted -> PC_Write=1, PC_Sel=00, Halted=1 next cycle; IMem_Req stays 0 for 20 cycles with Start=1.
- IMem_Ack held 0 -> ERROR after 15 wait cycles; Timeout_Err=1, IMem_Req=0; later ack ignored; Reset pulse clears everything to IDLE.
- Reset asserted mid-REQ between clock edges -> IMem_Req, Inst_Valid and counters 0 immediately; Fetch_Count preset near wrap via long run (CNT_WIDTH=4) -> 15 wraps to 0.
